vec_ram_packer: RTL and testbench
=================================

Name: vec_ram_packer

Overview:
- Write-side feeder for the 256-bit vector RAM.
- Accepts a burst command (start line address, start word offset, word count), then a stream of 32-bit words on a valid/ready handshake.
- Packs the words into 256-bit lines and issues one RAM write per line, with a per-byte write-enable mask, on a port that matches the RAM's en/we/addr/data interface.
- Partial first and last lines write only the bytes actually filled.

Parameters:
- ADDR_W, 24, line address width; must match the RAM address port.
- LEN_W, 16, width of the burst word-count field.

Ports:
- clk_i  input  1  clock, all logic on rising edge
- rst_i  input  1  synchronous, active-high reset
- cmd_valid_i  input  1  burst command valid
- cmd_ready_o  output  1  packer idle and able to accept a command
- cmd_addr_i  input  ADDR_W  first line address
- cmd_off_i  input  3  starting 32-bit word slot within the first line (0..7)
- cmd_len_i  input  LEN_W  number of 32-bit words in the burst (0 allowed)
- s_valid_i  input  1  data word valid
- s_ready_o  output  1  packer accepts a data word this cycle
- s_data_i  input  32  data word
- ram_en_o  output  1  RAM enable, high only on write cycles
- ram_we_o  output  32  byte write enables, bit b covers ram_d_o[8b+7:8b]
- ram_addr_o  output  ADDR_W  RAM line address
- ram_d_o  output  256  RAM write data
- busy_o  output  1  a burst is in progress
- done_o  output  1  one-cycle pulse when a burst completes

Behaviour:
- Reset: state IDLE.
  - cmd_ready_o=0, s_ready_o=0, ram_en_o=0, ram_we_o=0, ram_addr_o=0, ram_d_o=0, busy_o=0, done_o=0.
  - Internal mask, slot and count registers cleared.
  - cmd_ready_o becomes 1 the cycle after rst_i deasserts.
- States: IDLE, FILL, WRITE, DONE.
- IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i&&cmd_ready_o: latch address, slot=cmd_off_i, remaining=cmd_len_i, clear mask and line buffer.
  - Next state is FILL, or DONE if cmd_len_i==0.
- FILL:
  - s_ready_o=1 and busy_o=1.
  - On s_valid_i&&s_ready_o: the word goes into line bits [32*slot+31:32*slot] and mask bits [4*slot+3:4*slot] are set.
  - remaining decrements; slot increments.
  - If slot was 7 or remaining reaches 0, next state is WRITE.
  - No timeout; FILL waits indefinitely for s_valid_i.
- WRITE (exactly one cycle):
  - s_ready_o=0, ram_en_o=1, ram_we_o=mask, ram_addr_o=line address.
  - ram_d_o=line buffer, with unfilled lanes driven 0.
  - Next cycle: line address +1 modulo 2^ADDR_W, slot=0, mask and buffer cleared.
  - Next state is FILL if remaining>0, else DONE.
- DONE (one cycle): done_o=1, busy_o=0, then IDLE.
- Outside WRITE:
  - ram_en_o=0 and ram_we_o=0.
  - ram_addr_o and ram_d_o hold their last values.
- Throughput: a full line costs 8 accept cycles plus 1 write cycle.
- Latency: last word accepted at cycle t → RAM write at t+1, done_o at t+2, cmd_ready_o at t+3.
- The RAM also performs a read on every enabled cycle; the packer ignores the read data.
- Commands are not accepted while busy; cmd_ready_o=0 from FILL through DONE.
- Overlong burst: cmd_off_i+cmd_len_i greater than 8 spans multiple lines; every line after the first starts at slot 0.
- Reset mid-burst: the partial line is discarded and no RAM write is issued. Outputs return to reset values on the next edge.
- s_valid_i asserted while s_ready_o=0 is ignored; the word is not consumed.

Test Plan:
- Aligned burst: addr=0x000010, off=0, len=8, words 0x11111111..0x88888888 back-to-back → one write at 0x000010, we=0xFFFFFFFF, d_o[31:0]=0x11111111, d_o[255:224]=0x88888888; done_o 2 cycles after the 8th accept.
- Unaligned split: addr=0x000020, off=5, len=6 →
  - write 1 at 0x000020 with we=0xFFF00000 (slots 5..7);
  - write 2 at 0x000021 with we=0x00000FFF (slots 0..2);
  - other lanes of d_o are 0.
- Zero length: len=0 → no ram_en_o pulse; done_o high the cycle after command accept; cmd_ready_o high the cycle after that.
- Stalled source: len=3, off=0, with s_valid_i toggling 1,0,0,1,0,1 → exactly 3 words accepted; single write with we=0x00000FFF; no extra accepts.
- Address wrap: addr=0xFFFFFF, off=0, len=16 → writes at 0xFFFFFF then 0x000000, both with we=0xFFFFFFFF.
- Reset mid-burst: len=8, assert rst_i after 4 accepts → no ram_en_o pulse, no done_o; cmd_ready_o=0 during reset and 1 one cycle after release.

Source files
------------

// File: rtl/vec_ram_packer.sv
// ---------------------------------------------------------------------------
// vec_ram_packer
//   Write-side feeder for the 256-bit vector RAM. A burst command gives the
//   first line address, the starting 32-bit slot inside that line and a word
//   count. The packer then takes 32-bit words over a valid/ready handshake,
//   packs them into 256-bit lines and issues one masked RAM write per line.
//   Partial first/last lines only enable the bytes that were actually filled.
//
// Ports
//   clk_i        clock, all logic on the rising edge
//   rst_i        synchronous, active-high reset
//   cmd_valid_i  burst command valid
//   cmd_ready_o  packer idle, command accepted when cmd_valid_i is high
//   cmd_addr_i   first line address
//   cmd_off_i    starting 32-bit slot in the first line (0..7)
//   cmd_len_i    number of 32-bit words in the burst (0 allowed)
//   s_valid_i    data word valid
//   s_ready_o    packer takes a data word this cycle
//   s_data_i     data word
//   ram_en_o     RAM enable, high only on write cycles
//   ram_we_o     byte write enables, bit b covers ram_d_o[8b+7:8b]
//   ram_addr_o   RAM line address
//   ram_d_o      RAM write data
//   busy_o       a burst is in progress
//   done_o       one-cycle pulse when a burst completes
// ---------------------------------------------------------------------------
module vec_ram_packer #(
    parameter int ADDR_W = 24,
    parameter int LEN_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [2:0]        cmd_off_i,
    input  logic [LEN_W-1:0]  cmd_len_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    input  logic [31:0]       s_data_i,
    output logic              ram_en_o,
    output logic [31:0]       ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [255:0]      ram_d_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Byte-enable nibble for one 32-bit slot of the line.
    function automatic logic [31:0] lane_mask(input logic [2:0] slot);
        lane_mask = 32'h0000_000F << {slot, 2'b00};
    endfunction

    // Line buffer with one 32-bit slot replaced by a new word.
    function automatic logic [255:0] insert_word(input logic [255:0] line,
                                                 input logic [2:0]   slot,
                                                 input logic [31:0]  word);
        logic [255:0] res;
        res = line;
        res[{slot, 5'b00000} +: 32] = word;
        return res;
    endfunction

    // Internal state
    state_t              state_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [2:0]          slot_r;
    logic [LEN_W-1:0]    rem_r;
    logic [31:0]         mask_r;
    logic [255:0]        line_r;

    // Registered outputs
    logic                cmd_ready_r;
    logic                s_ready_r;
    logic                ram_en_r;
    logic [31:0]         ram_we_r;
    logic [ADDR_W-1:0]   ram_addr_r;
    logic [255:0]        ram_d_r;
    logic                busy_r;
    logic                done_r;

    // Next-state values
    state_t              state_s;
    logic [ADDR_W-1:0]   addr_s;
    logic [2:0]          slot_s;
    logic [LEN_W-1:0]    rem_s;
    logic [31:0]         mask_s;
    logic [255:0]        line_s;
    logic                cmd_fire_s;
    logic                data_fire_s;

    // Handshakes qualify on the registered ready flags so a held-off
    // valid (during reset or outside FILL) is never consumed.
    assign cmd_fire_s  = cmd_valid_i && cmd_ready_r;
    assign data_fire_s = s_valid_i && s_ready_r;

    // Next-state and datapath update logic.
    always_comb begin
        state_s = state_r;
        addr_s  = addr_r;
        slot_s  = slot_r;
        rem_s   = rem_r;
        mask_s  = mask_r;
        line_s  = line_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_fire_s) begin
                    addr_s = cmd_addr_i;
                    slot_s = cmd_off_i;
                    rem_s  = cmd_len_i;
                    mask_s = 32'h0;
                    line_s = 256'h0;
                    if (cmd_len_i == {LEN_W{1'b0}}) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_FILL;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (data_fire_s) begin
                    line_s = insert_word(line_r, slot_r, s_data_i);
                    mask_s = mask_r | lane_mask(slot_r);
                    rem_s  = rem_r - LEN_W'(1);
                    slot_s = slot_r + 3'd1;
                    // Flush when the line is full or the burst has ended.
                    if ((slot_r == 3'd7) || (rem_r == LEN_W'(1))) begin
                        state_s = ST_WRITE;
                    end else begin
                        state_s = ST_FILL;
                    end
                end else begin
                    state_s = ST_FILL;
                end
            end
            ST_WRITE: begin
                // The line has been handed to the output registers on the
                // way in; prepare an empty line at the next address.
                addr_s = addr_r + ADDR_W'(1);
                slot_s = 3'd0;
                mask_s = 32'h0;
                line_s = 256'h0;
                if (rem_r != {LEN_W{1'b0}}) begin
                    state_s = ST_FILL;
                end else begin
                    state_s = ST_DONE;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and packing registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            addr_r  <= {ADDR_W{1'b0}};
            slot_r  <= 3'd0;
            rem_r   <= {LEN_W{1'b0}};
            mask_r  <= 32'h0;
            line_r  <= 256'h0;
        end else begin
            state_r <= state_s;
            addr_r  <= addr_s;
            slot_r  <= slot_s;
            rem_r   <= rem_s;
            mask_r  <= mask_s;
            line_r  <= line_s;
        end
    end

    // Output registers, decoded from the upcoming state so each output is
    // valid in the same cycle the FSM occupies that state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cmd_ready_r <= 1'b0;
            s_ready_r   <= 1'b0;
            ram_en_r    <= 1'b0;
            ram_we_r    <= 32'h0;
            ram_addr_r  <= {ADDR_W{1'b0}};
            ram_d_r     <= 256'h0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            cmd_ready_r <= (state_s == ST_IDLE);
            s_ready_r   <= (state_s == ST_FILL);
            ram_en_r    <= (state_s == ST_WRITE);
            busy_r      <= (state_s == ST_FILL) || (state_s == ST_WRITE);
            done_r      <= (state_s == ST_DONE);
            if (state_s == ST_WRITE) begin
                // Address and data hold their last values outside writes.
                ram_we_r   <= mask_s;
                ram_addr_r <= addr_s;
                ram_d_r    <= line_s;
            end else begin
                ram_we_r   <= 32'h0;
            end
        end
    end

    assign cmd_ready_o = cmd_ready_r;
    assign s_ready_o   = s_ready_r;
    assign ram_en_o    = ram_en_r;
    assign ram_we_o    = ram_we_r;
    assign ram_addr_o  = ram_addr_r;
    assign ram_d_o     = ram_d_r;
    assign busy_o      = busy_r;
    assign done_o      = done_r;

endmodule

// File: tb/tb_vec_ram_packer.sv
// ---------------------------------------------------------------------------
// tb_vec_ram_packer
//   Self-checking bench for vec_ram_packer: a table of directed bursts with
//   hand-derived expectations, hand-written reset sequences and randomized
//   bursts compared against a line-level reference model.
// ---------------------------------------------------------------------------
module tb_vec_ram_packer;

    localparam int ADDR_W = 24;
    localparam int LEN_W  = 16;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic [ADDR_W-1:0] cmd_addr_i;
    logic [2:0]        cmd_off_i;
    logic [LEN_W-1:0]  cmd_len_i;
    logic              s_valid_i;
    logic              s_ready_o;
    logic [31:0]       s_data_i;
    logic              ram_en_o;
    logic [31:0]       ram_we_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [255:0]      ram_d_o;
    logic              busy_o;
    logic              done_o;

    always #5 clk_i = ~clk_i;

    vec_ram_packer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_addr_i (cmd_addr_i),
        .cmd_off_i  (cmd_off_i),
        .cmd_len_i  (cmd_len_i),
        .s_valid_i  (s_valid_i),
        .s_ready_o  (s_ready_o),
        .s_data_i   (s_data_i),
        .ram_en_o   (ram_en_o),
        .ram_we_o   (ram_we_o),
        .ram_addr_o (ram_addr_o),
        .ram_d_o    (ram_d_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    typedef struct {
        logic [23:0]  addr;
        logic [31:0]  we;
        logic [255:0] d;
    } wr_t;

    typedef struct {
        logic [23:0] addr;
        logic [2:0]  off;
        int          len;
        int          stall;     // percent idle cycles, -1 = fixed toggle pattern
        int          pattern;   // 1 = words 0x11111111*(i+1)
        int          nwr;
        logic [31:0] we_first;
        logic [31:0] we_last;
        logic [23:0] addr_last;
    } vec_t;

    wr_t         got_q[$];
    wr_t         exp_q[$];
    logic [31:0] words_q[$];
    vec_t        tbl[7];
    int          vpat[6] = '{1, 0, 0, 1, 0, 1};

    int cyc = 0, acc_cnt = 0, done_cnt = 0;
    int last_acc_cyc = 0, last_wr_cyc = 0, last_done_cyc = 0, last_cmd_cyc = 0;
    int n_checks = 0, n_fail = 0;

    // Observe DUT activity away from the active edge.
    always @(negedge clk_i) begin
        cyc <= cyc + 1;
        if (s_valid_i && s_ready_o) begin
            acc_cnt      <= acc_cnt + 1;
            last_acc_cyc <= cyc;
        end
        if (cmd_valid_i && cmd_ready_o) last_cmd_cyc <= cyc;
        if (ram_en_o) begin
            got_q.push_back('{ram_addr_o, ram_we_o, ram_d_o});
            last_wr_cyc <= cyc;
        end
        if (done_o) begin
            done_cnt      <= done_cnt + 1;
            last_done_cyc <= cyc;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_i(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_v(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: word i lands at absolute slot off+i, i.e. line
    // (off+i)/8 and slot (off+i)%8 counted from the start address.
    task automatic build_model(input logic [23:0] a, input int off, input int len);
        int  nl;
        wr_t e;
        exp_q.delete();
        nl = (len == 0) ? 0 : (off + len + 7) / 8;
        for (int l = 0; l < nl; l++) begin
            e.addr = a + 24'(l);
            e.we   = 32'h0;
            e.d    = 256'h0;
            exp_q.push_back(e);
        end
        for (int i = 0; i < len; i++) begin
            int p;
            p = off + i;
            e = exp_q[p / 8];
            e.d[32 * (p % 8) +: 32] = words_q[i];
            e.we[4 * (p % 8) +: 4]  = 4'hF;
            exp_q[p / 8] = e;
        end
    endtask

    task automatic send_cmd(input logic [23:0] a, input logic [2:0] off, input int len,
                            input string name);
        logic ok;
        int   guard;
        cmd_addr_i  = a;
        cmd_off_i   = off;
        cmd_len_i   = LEN_W'(len);
        cmd_valid_i = 1'b1;
        ok = 1'b0;
        guard = 0;
        while (!ok && guard < 20) begin
            @(negedge clk_i);
            ok = cmd_ready_o;
            @(posedge clk_i); #1;
            guard++;
        end
        cmd_valid_i = 1'b0;
        check_i({name, "/cmd_accept"}, int'(ok), 1);
    endtask

    task automatic run_burst(input logic [23:0] a, input logic [2:0] off, input int len,
                             input int stall, input int wmode, input string name);
        int   base, dbase, abase, idx, k, guard;
        logic v, acc, found;
        words_q.delete();
        for (int i = 0; i < len; i++)
            words_q.push_back((wmode == 1) ? 32'h11111111 * 32'(i + 1) : $urandom);
        build_model(a, int'(off), len);
        base  = got_q.size();
        dbase = done_cnt;
        abase = acc_cnt;
        send_cmd(a, off, len, name);
        idx = 0; k = 0; guard = 0;
        while (idx < len && guard < len * 20 + 50) begin
            if (stall < 0) v = (k < 6) ? (vpat[k] != 0) : 1'b1;
            else           v = ($urandom_range(99) >= stall);
            s_valid_i = v;
            s_data_i  = v ? words_q[idx] : $urandom;
            @(negedge clk_i);
            acc = s_valid_i && s_ready_o;
            @(posedge clk_i); #1;
            if (acc) idx++;
            k++; guard++;
        end
        check_i({name, "/words_sent"}, idx, len);
        // Hold valid high after the burst: nothing more may be consumed.
        s_valid_i = 1'b1;
        s_data_i  = $urandom;
        found = 1'b0; guard = 0;
        while (!found && guard < 30) begin
            @(negedge clk_i);
            if (done_o) begin
                found = 1'b1;
                check_i({name, "/cmd_ready_in_done"}, int'(cmd_ready_o), 0);
                check_i({name, "/busy_in_done"}, int'(busy_o), 0);
            end
            @(posedge clk_i); #1;
            guard++;
        end
        check_i({name, "/done_seen"}, int'(found), 1);
        @(negedge clk_i);
        if (found) check_i({name, "/cmd_ready_after_done"}, int'(cmd_ready_o), 1);
        @(posedge clk_i); #1;
        s_valid_i = 1'b0;
        check_i({name, "/accepts"}, acc_cnt - abase, len);
        check_i({name, "/done_pulses"}, done_cnt - dbase, 1);
        check_i({name, "/writes"}, got_q.size() - base, exp_q.size());
        for (int j = 0; j < exp_q.size(); j++) begin
            if (base + j < got_q.size()) begin
                check_v({name, "/addr"}, 256'(got_q[base + j].addr), 256'(exp_q[j].addr));
                check_v({name, "/we"}, 256'(got_q[base + j].we), 256'(exp_q[j].we));
                check_v({name, "/data"}, got_q[base + j].d, exp_q[j].d);
            end
        end
        if (len > 0) begin
            check_i({name, "/write_latency"}, last_wr_cyc - last_acc_cyc, 1);
            check_i({name, "/done_latency"}, last_done_cyc - last_acc_cyc, 2);
        end else begin
            check_i({name, "/zero_len_done_latency"}, last_done_cyc - last_cmd_cyc, 1);
        end
    endtask

    initial begin
        int          b, dbase, abase;
        logic [23:0] ra;
        string       nm;

        tbl[0] = '{24'h000010, 3'd0, 8,  0, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 24'h000010};
        tbl[1] = '{24'h000020, 3'd5, 6,  0, 0, 2, 32'hFFF00000, 32'h00000FFF, 24'h000021};
        tbl[2] = '{24'h000030, 3'd0, 0,  0, 0, 0, 32'h00000000, 32'h00000000, 24'h000000};
        tbl[3] = '{24'h000060, 3'd0, 3, -1, 0, 1, 32'h00000FFF, 32'h00000FFF, 24'h000060};
        tbl[4] = '{24'hFFFFFF, 3'd0, 16, 0, 0, 2, 32'hFFFFFFFF, 32'hFFFFFFFF, 24'h000000};
        tbl[5] = '{24'h000040, 3'd7, 1,  0, 0, 1, 32'hF0000000, 32'hF0000000, 24'h000040};
        tbl[6] = '{24'h000100, 3'd3, 20, 40, 0, 3, 32'hFFFFF000, 32'h0FFFFFFF, 24'h000102};

        rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_addr_i = 24'h0; cmd_off_i = 3'd0;
        cmd_len_i = 16'h0; s_valid_i = 1'b0; s_data_i = 32'h0;

        // Reset state
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_i("rst/cmd_ready", int'(cmd_ready_o), 0);
        check_i("rst/s_ready", int'(s_ready_o), 0);
        check_i("rst/ram_en", int'(ram_en_o), 0);
        check_v("rst/ram_we", 256'(ram_we_o), 256'h0);
        check_v("rst/ram_addr", 256'(ram_addr_o), 256'h0);
        check_v("rst/ram_d", ram_d_o, 256'h0);
        check_i("rst/busy", int'(busy_o), 0);
        check_i("rst/done", int'(done_o), 0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check_i("rst_release/cmd_ready_same_cycle", int'(cmd_ready_o), 0);
        @(negedge clk_i);
        check_i("rst_release/cmd_ready_next_cycle", int'(cmd_ready_o), 1);
        @(posedge clk_i); #1;

        // Directed table
        for (int i = 0; i < 7; i++) begin
            nm = $sformatf("vec%0d", i);
            b = got_q.size();
            run_burst(tbl[i].addr, tbl[i].off, tbl[i].len, tbl[i].stall, tbl[i].pattern, nm);
            check_i({nm, "/nwr"}, got_q.size() - b, tbl[i].nwr);
            if (tbl[i].nwr > 0 && got_q.size() >= b + tbl[i].nwr) begin
                check_v({nm, "/we_first"}, 256'(got_q[b].we), 256'(tbl[i].we_first));
                check_v({nm, "/we_last"}, 256'(got_q[b + tbl[i].nwr - 1].we), 256'(tbl[i].we_last));
                check_v({nm, "/addr_last"}, 256'(got_q[b + tbl[i].nwr - 1].addr),
                        256'(tbl[i].addr_last));
                if (tbl[i].pattern == 1) begin
                    check_v({nm, "/d_low"}, 256'(got_q[b].d[31:0]), 256'(32'h11111111));
                    check_v({nm, "/d_high"}, 256'(got_q[b].d[255:224]), 256'(32'h88888888));
                end
            end
        end

        // Reset in the middle of a burst
        b = got_q.size(); dbase = done_cnt; abase = acc_cnt;
        send_cmd(24'h000050, 3'd0, 8, "midrst");
        for (int i = 0; i < 40 && acc_cnt - abase < 4; i++) begin
            s_valid_i = (acc_cnt - abase < 4);
            s_data_i  = $urandom;
            @(negedge clk_i);
            @(posedge clk_i); #1;
        end
        s_valid_i = 1'b0;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        s_valid_i = 1'b1;
        @(negedge clk_i);
        check_i("midrst/cmd_ready", int'(cmd_ready_o), 0);
        check_i("midrst/s_ready", int'(s_ready_o), 0);
        check_i("midrst/busy", int'(busy_o), 0);
        check_v("midrst/ram_d", ram_d_o, 256'h0);
        check_v("midrst/ram_addr", 256'(ram_addr_o), 256'h0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check_i("midrst/cmd_ready_release", int'(cmd_ready_o), 0);
        @(negedge clk_i);
        check_i("midrst/cmd_ready_after", int'(cmd_ready_o), 1);
        @(posedge clk_i); #1;
        s_valid_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #1;
        check_i("midrst/no_write", got_q.size() - b, 0);
        check_i("midrst/no_done", done_cnt - dbase, 0);
        check_i("midrst/accepts", acc_cnt - abase, 4);

        // Randomized bursts against the reference model
        for (int r = 0; r < 25; r++) begin
            if ($urandom_range(3) == 0) ra = 24'hFFFFFF - 24'($urandom_range(2));
            else                        ra = 24'($urandom);
            run_burst(ra, 3'($urandom_range(7)), $urandom_range(20),
                      $urandom_range(60), 0, $sformatf("rnd%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
